nonce_tx_queue: RTL and testbench
=================================

NONCE_TX_QUEUE -- requirements
Module: nonce_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter DEDUP, default 1; when 1, a nonce equal to the last accepted nonce is dropped.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port nonce_valid, input, 1 bit: one-cycle strobe from the hashing core marking a golden nonce.
REQ-006 SHALL have port nonce, input, 32 bits: the golden nonce value, sampled when nonce_valid=1.
REQ-007 SHALL have port tx_busy, input, 1 bit: busy flag from the serial core's transmitter.
REQ-008 SHALL have port tx_ready, output, 1 bit: one-cycle start strobe to the serial core.
REQ-009 SHALL have port word, output, 32 bits: the nonce being sent, to the serial core.
REQ-010 SHALL have port count, output, $clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag set when a nonce is lost.
REQ-012 SHALL have port ovf_clr, input, 1 bit: synchronous clear for overflow.

Function
REQ-013 SHALL store accepted nonces in a circular FIFO with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-014 SHALL accept a push on nonce_valid=1 unless the nonce is dropped by DEDUP or rejected because the FIFO is full.
REQ-015 SHALL, with DEDUP=1, hold the last accepted nonce in a register with a valid bit that is cleared by reset, and drop any new nonce equal to it.
REQ-016 SHALL complete a push on the same cycle as a pop when the FIFO is full, with no overflow.
REQ-017 SHALL drop the newest nonce when the FIFO is full and no pop occurs that cycle, and set overflow on the next edge.
REQ-018 SHALL give ovf_clr priority below a same-cycle overflow event, so the flag stays set.
REQ-019 SHALL implement the FSM states IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-020 SHALL move IDLE to START when count is not 0 and tx_busy=0: word is loaded with the FIFO head, the entry is popped, and tx_ready=1 for exactly that one cycle.
REQ-021 SHALL move START to WAIT_BUSY unconditionally, with tx_ready=0.
REQ-022 SHALL move WAIT_BUSY to WAIT_DONE when tx_busy=1, or back to IDLE when tx_busy stays 0 for 8 cycles (watchdog, 3-bit counter).
REQ-023 SHALL move WAIT_DONE to IDLE when tx_busy=0.
REQ-024 SHALL hold word stable from the tx_ready cycle until the next load.
REQ-025 SHALL have a minimum gap of 3 cycles between consecutive tx_ready pulses.
REQ-026 SHALL update count every cycle as count + push - pop, never exceeding DEPTH and never going below 0.
REQ-027 SHALL make a nonce pushed into an empty FIFO while in IDLE with tx_busy=0 produce tx_ready exactly 1 cycle after the nonce_valid cycle.

Reset
REQ-028 SHALL, while rst_n=0, force: FSM to IDLE, pointers to 0, count 0, tx_ready 0, word 32'h0, overflow 0, dedup valid 0, watchdog 0.
REQ-029 SHALL, if reset is asserted mid-transmission, discard FIFO contents and the in-flight state, and emit no tx_ready until a new nonce is accepted after rst_n rises.
REQ-030 SHALL not apply reset to the FIFO storage array.

Structure
REQ-031 SHALL take the FSM state encoding (2-bit) and the watchdog limit constant (8) from the shared miner package.
REQ-032 SHALL contain exactly one natural sub-module, sync_fifo, holding the storage, pointers, count, and the full and empty flags.
REQ-033 SHALL keep the FSM, dedup and overflow logic in nonce_tx_queue itself.

Verification
REQ-034 SHALL cover: single nonce 32'hDEADBEEF pushed with tx_busy=0 -> tx_ready high 1 cycle after the push, word=32'hDEADBEEF, count 1 then 0.
REQ-035 SHALL cover: pushes of 32'h1, 32'h2 and 32'h3 back to back, with tx_busy high for 40 cycles after each tx_ready -> three tx_ready pulses in order 1, 2, 3, and no pulse while tx_busy=1.
REQ-036 SHALL cover: DEPTH=4 with tx_busy held 1, then 6 distinct pushes -> count=4, overflow=1, and the transmitted sequence is the first 4 values only.
REQ-037 SHALL cover: DEDUP=1 with 32'hA5A5A5A5 pushed twice, then 32'h0 -> exactly 2 transmissions: A5A5A5A5 then 0.
REQ-038 SHALL cover: tx_busy never rises after tx_ready -> FSM returns to IDLE after 8 cycles, and the next queued nonce is sent.
REQ-039 SHALL cover: rst_n pulsed low during WAIT_DONE with 2 entries queued -> count=0, tx_ready stays 0, overflow=0; a new push of 32'h7 is then sent normally.

Source files
------------

// File: rtl/nonce_tx_queue_pkg.sv
// nonce_tx_queue_pkg: shared miner constants for the golden-nonce transmit path
// Contents:
//   tx_state_e  - 2-bit transmit handshake FSM encoding
//   WDOG_LIMIT  - cycles WAIT_BUSY waits for tx_busy before giving up
//   WDOG_W      - watchdog counter width
//   WDOG_LAST   - watchdog value on which the timeout fires
package nonce_tx_queue_pkg;
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } tx_state_e;
   localparam int WDOG_LIMIT = 8;
   localparam int WDOG_W = $clog2(WDOG_LIMIT);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: circular FIFO with occupancy count and full/empty flags
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset (storage is not reset)
//   push_i, wdata_i - write request and data; ignored when full unless popping
//   pop_i, rdata_o  - read request and head-of-queue data
//   count_o         - occupancy, 0..DEPTH
//   full_o, empty_o - occupancy flags
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             wdata_i,
   output logic [W-1:0]             rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q;
   logic do_push, do_pop;
   always_comb begin
      empty_o = count_q == '0;
      full_o = count_q == CW'(DEPTH);
      do_pop = pop_i && !empty_o;
      // a full FIFO still takes a write when the head leaves on the same edge
      do_push = push_i && (!full_o || do_pop);
      rdata_o = mem_q[rptr_q];
      count_o = count_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         count_q <= '0;
      end else begin
         wptr_q <= wptr_q + AW'(do_push);
         rptr_q <= rptr_q + AW'(do_pop);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end
endmodule

// File: rtl/nonce_tx_queue.sv
// nonce_tx_queue: queues golden nonces and hands them one at a time to the serial transmitter
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   nonce_valid, nonce  - one-cycle strobe and value of a found nonce
//   tx_busy             - transmitter busy flag
//   tx_ready, word      - one-cycle start strobe and the word to send (held until next load)
//   count               - FIFO occupancy
//   overflow, ovf_clr   - sticky lost-nonce flag and its synchronous clear
module nonce_tx_queue
   import nonce_tx_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DEDUP = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   nonce_valid,
   input  logic [31:0]            nonce,
   input  logic                   tx_busy,
   output logic                   tx_ready,
   output logic [31:0]            word,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   input  logic                   ovf_clr
);
   tx_state_e state_q;
   logic [WDOG_W-1:0] wd_q;
   logic tx_ready_q;
   logic [31:0] word_q, head, last_q, last_d;
   logic last_v_q, last_v_d, overflow_q, overflow_d;
   logic full, empty, dup, pop, push, lost;
   sync_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (nonce),
      .rdata_o (head),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );
   always_comb begin
      dup = (DEDUP != 0) && last_v_q && nonce == last_q;
      pop = state_q == IDLE && !empty && !tx_busy;
      push = nonce_valid && !dup && (!full || pop);
      lost = nonce_valid && !dup && full && !pop;
      // a nonce lost this cycle outranks a clear request
      overflow_d = lost || (overflow_q && !ovf_clr);
      last_d = push ? nonce : last_q;
      last_v_d = last_v_q || push;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= '0;
         last_v_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         last_q <= last_d;
         last_v_q <= last_v_d;
         overflow_q <= overflow_d;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tx_ready_q <= 1'b0;
         word_q <= '0;
         wd_q <= '0;
      end else begin
         tx_ready_q <= 1'b0;
         case (state_q)
            IDLE: if (pop) begin
               state_q <= START;
               tx_ready_q <= 1'b1;
               word_q <= head;
            end
            START: begin
               state_q <= WAIT_BUSY;
               wd_q <= '0;
            end
            // give up on a transmitter that never acknowledges the start strobe
            WAIT_BUSY: if (tx_busy) state_q <= WAIT_DONE;
               else if (wd_q == WDOG_LAST) state_q <= IDLE;
               else wd_q <= wd_q + 1'b1;
            WAIT_DONE: if (!tx_busy) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign tx_ready = tx_ready_q;
   assign word = word_q;
   assign overflow = overflow_q;
endmodule

// File: tb/tb_nonce_tx_queue.sv
// tb_nonce_tx_queue: directed self-checking bench with a queue-based reference model
module tb_nonce_tx_queue;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic nonce_valid = 1'b0;
   logic [31:0] nonce = '0;
   logic ovf_clr = 1'b0;
   logic force_busy = 1'b0;
   int busy_len = 0;
   int bcnt = 0;
   wire tx_busy = force_busy || bcnt != 0;
   logic tx_ready, overflow;
   logic [31:0] word;
   logic [2:0] count;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [31:0] sent[$];
   int pt[$];
   logic [31:0] expq[$];
   // values seen by the DUT at the last rising edge
   logic s_valid = 1'b0, s_busy = 1'b0, s_clr = 1'b0, s_rst = 1'b0;
   logic [31:0] s_nonce = '0;
   // reference model state
   logic [31:0] mq[$];
   logic [31:0] m_last = '0, m_word = '0;
   bit m_last_v, m_ovf, m_ready, m_fly, m_fresh, m_gotb;
   int m_quiet;
   bit send, full, dup, lost;

   nonce_tx_queue #(.DEPTH(DEPTH), .DEDUP(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .nonce_valid (nonce_valid),
      .nonce       (nonce),
      .tx_busy     (tx_busy),
      .tx_ready    (tx_ready),
      .word        (word),
      .count       (count),
      .overflow    (overflow),
      .ovf_clr     (ovf_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      s_valid <= nonce_valid;
      s_nonce <= nonce;
      s_busy <= tx_busy;
      s_clr <= ovf_clr;
      s_rst <= rst_n;
   end

   // transmitter stand-in: raises busy for busy_len cycles after each start strobe
   initial forever begin
      @(negedge clk);
      if (!rst_n) bcnt = 0;
      else if (tx_ready && busy_len > 0) bcnt = busy_len;
      else if (bcnt > 0) bcnt--;
   end

   // model step for the last rising edge, then compare against the DUT
   initial forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n || !s_rst) begin
         mq.delete();
         m_last_v = 0; m_ovf = 0; m_ready = 0; m_word = '0;
         m_fly = 0; m_fresh = 0; m_gotb = 0; m_quiet = 0;
      end else begin
         send = !m_fly && mq.size() > 0 && !s_busy;
         full = mq.size() == DEPTH;
         dup = m_last_v && s_nonce == m_last;
         lost = s_valid && !dup && full && !send;
         if (m_fly) begin
            if (m_fresh) m_fresh = 0;
            else if (m_gotb) begin
               if (!s_busy) m_fly = 0;
            end else if (s_busy) m_gotb = 1;
            else begin
               m_quiet++;
               if (m_quiet == 8) m_fly = 0;
            end
         end
         m_ready = send;
         if (send) begin
            m_word = mq.pop_front();
            m_fly = 1; m_fresh = 1; m_gotb = 0; m_quiet = 0;
         end
         if (s_valid && !dup && !lost) begin
            mq.push_back(s_nonce);
            m_last = s_nonce;
            m_last_v = 1;
         end
         if (lost) m_ovf = 1;
         else if (s_clr) m_ovf = 0;
      end
      checks++;
      if (tx_ready !== m_ready || word !== m_word || count !== 3'(mq.size()) || overflow !== m_ovf) begin
         failures++;
         $display("FAIL cycle_cmp cyc=%0d: got rdy=%b word=%h cnt=%0d ovf=%b want rdy=%b word=%h cnt=%0d ovf=%b",
                  cyc, tx_ready, word, count, overflow, m_ready, m_word, mq.size(), m_ovf);
      end
      if (tx_ready === 1'b1) begin
         sent.push_back(word);
         pt.push_back(cyc);
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic push(logic [31:0] v);
      nonce_valid = 1'b1;
      nonce = v;
      @(negedge clk);
      nonce_valid = 1'b0;
   endtask

   task automatic drain(string nm, int maxc);
      int n = 0;
      while ((mq.size() != 0 || m_fly) && n < maxc) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= maxc) begin
         failures++;
         $display("FAIL %s: queue not drained after %0d cycles", nm, n);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_sent(string nm);
      checks++;
      if (sent.size() != expq.size()) begin
         failures++;
         $display("FAIL %s: got %0d pulses want %0d", nm, sent.size(), expq.size());
      end else begin
         foreach (expq[i]) chk($sformatf("%s[%0d]", nm, i), sent[i], expq[i]);
      end
      sent.delete();
      pt.delete();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_ready", 32'(tx_ready), 32'd0);
      chk("rst_word", word, 32'h0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      @(negedge clk);
      // single nonce
      busy_len = 3;
      push(32'hDEADBEEF);
      chk("t1_count1", 32'(count), 32'd1);
      chk("t1_ready0", 32'(tx_ready), 32'd0);
      @(negedge clk);
      chk("t1_ready1", 32'(tx_ready), 32'd1);
      chk("t1_word", word, 32'hDEADBEEF);
      chk("t1_count0", 32'(count), 32'd0);
      @(negedge clk);
      chk("t1_one_pulse", 32'(tx_ready), 32'd0);
      drain("t1_drain", 100);
      expq = '{32'hDEADBEEF};
      check_sent("t1_seq");
      // three back-to-back nonces, long busy
      busy_len = 40;
      push(32'h1); push(32'h2); push(32'h3);
      drain("t2_drain", 400);
      chk("t2_gap1", 32'(pt[1] - pt[0]), 32'd42);
      chk("t2_gap2", 32'(pt[2] - pt[1]), 32'd42);
      expq = '{32'h1, 32'h2, 32'h3};
      check_sent("t2_seq");
      // overflow with transmitter held busy
      force_busy = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 6; i++) push(32'h10 + 32'(i));
      chk("t3_count", 32'(count), 32'd4);
      chk("t3_ovf", 32'(overflow), 32'd1);
      chk("t3_noready", 32'(tx_ready), 32'd0);
      ovf_clr = 1'b1;
      push(32'h16);
      ovf_clr = 1'b0;
      chk("t3_ovf_prio", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("t3_ovf_clr", 32'(overflow), 32'd0);
      busy_len = 5;
      force_busy = 1'b0;
      push(32'h20);
      chk("t3_full_pushpop_cnt", 32'(count), 32'd4);
      chk("t3_full_pushpop_ovf", 32'(overflow), 32'd0);
      drain("t3_drain", 400);
      expq = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h20};
      check_sent("t3_seq");
      // duplicate suppression
      push(32'hA5A5A5A5); push(32'hA5A5A5A5); push(32'h0);
      drain("t4_drain", 200);
      expq = '{32'hA5A5A5A5, 32'h0};
      check_sent("t4_seq");
      // transmitter never acknowledges: watchdog
      busy_len = 0;
      push(32'h100); push(32'h101);
      drain("t5_drain", 200);
      chk("t5_gap", 32'(pt[1] - pt[0]), 32'd10);
      expq = '{32'h100, 32'h101};
      check_sent("t5_seq");
      // reset during WAIT_DONE
      busy_len = 30;
      push(32'h200); push(32'h201); push(32'h202);
      begin
         int n = 0;
         while (sent.size() < 1 && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      repeat (5) @(negedge clk);
      chk("t6_count_pre", 32'(count), 32'd2);
      @(posedge clk); #2 rst_n = 1'b0;
      @(negedge clk);
      chk("t6_rst_count", 32'(count), 32'd0);
      chk("t6_rst_ready", 32'(tx_ready), 32'd0);
      chk("t6_rst_ovf", 32'(overflow), 32'd0);
      chk("t6_rst_word", word, 32'h0);
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (20) @(negedge clk);
      expq = '{32'h200};
      check_sent("t6_no_pulse");
      busy_len = 5;
      push(32'h7);
      drain("t6_drain", 100);
      expq = '{32'h7};
      check_sent("t6_seq");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("FAIL timeout: bench did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
